// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the boot-time instruction-memory loader.
package loader_pkg;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 8 * LEN_BYTES;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;

    modport master (
        output byte_data, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_data
    );

    modport slave (
        input  byte_data, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_data
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs four stream bytes into a little-endian word and keeps the running XOR of payload bytes.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_o,
    output logic [31:0] word_o,
    output logic [7:0]  csum_o
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] asm_q, asm_d;
    logic [7:0]  csum_q, csum_d;

    // Bytes enter at the top so byte 0 ends up in bits 7:0 after four shifts.
    assign word_o      = {byte_i, asm_q[31:8]};
    assign word_done_o = en_i && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign csum_o      = csum_q;

    always_comb begin
        idx_d  = idx_q;
        asm_d  = asm_q;
        csum_d = csum_q;
        if (clear_i) begin
            idx_d  = '0;
            asm_d  = '0;
            csum_d = '0;
        end else if (en_i) begin
            idx_d  = idx_q + 2'd1;
            asm_d  = word_o;
            csum_d = csum_q ^ byte_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_q  <= '0;
            asm_q  <= '0;
            csum_q <= '0;
        end else begin
            idx_q  <= idx_d;
            asm_q  <= asm_d;
            csum_q <= csum_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: zero-fills instruction memory, writes a framed, checksummed image, then starts the CPU.
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    imem_loader_if.slave    bus,
    output logic            start_o,
    output logic            done_o,
    output logic            err_o,
    output logic [ADDR_W:0] word_cnt_o
);

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [LEN_W-1:0]  len_rx;
    logic              len_ok;
    logic              pack_en;
    logic              pack_clear;
    logic              word_done;
    logic [31:0]       word;
    logic [7:0]        csum;

    assign accept     = bus.byte_valid && ready_q;
    assign len_rx     = {bus.byte_data, len_lo_q};
    assign len_ok     = (len_rx != '0) && (len_rx <= LEN_W'(DEPTH));
    assign pack_en    = accept && (state_q == ST_DATA);
    assign pack_clear = accept && (state_q == ST_LEN1) && len_ok;

    byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (pack_clear),
        .en_i        (pack_en),
        .byte_i      (bus.byte_data),
        .word_done_o (word_done),
        .word_o      (word),
        .csum_o      (csum)
    );

    // The sweep counter runs one past DEPTH-1 so that ready rises one cycle after the last clear write.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = 1'b0;

        unique case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == (ADDR_W+1)'(DEPTH)) begin
                    state_d = ST_LEN0;
                end else begin
                    we_d      = 1'b1;
                    addr_d    = clr_cnt_q[ADDR_W-1:0];
                    data_d    = '0;
                    clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
                end
            end
            ST_LEN0: begin
                if (accept) begin
                    len_lo_d = bus.byte_data;
                    state_d  = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (accept) begin
                    if (len_ok) begin
                        len_d      = len_rx[ADDR_W:0];
                        word_cnt_d = '0;
                        state_d    = ST_DATA;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DATA: begin
                if (word_done) begin
                    we_d       = 1'b1;
                    addr_d     = word_cnt_q[ADDR_W-1:0];
                    data_d     = word;
                    word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
                    if (word_cnt_d == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (bus.byte_data == csum) ? ST_RUN : ST_ERR;
                end
            end
            ST_RUN, ST_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        ready_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                  (state_d == ST_DATA) || (state_d == ST_CSUM);
        start_d = (state_d == ST_RUN);
        done_d  = (state_d == ST_RUN);
        err_d   = (state_d == ST_ERR);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            len_lo_q   <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            start_q    <= start_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_data  = data_q;
    assign start_o        = start_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign word_cnt_o     = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame vectors, random frames with gaps, and reset corner cases.
module tb_imem_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            start_o;
    logic            done_o;
    logic            err_o;
    logic [ADDR_W:0] word_cnt_o;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus),
        .start_o    (start_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .word_cnt_o (word_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: records every write strobe the loader issues.
    logic [31:0] mem [DEPTH];
    int          writeCount = 0;
    int          cycleCount = 0;

    always @(posedge clk_i) begin
        cycleCount++;
        if (bus.imem_we) begin
            mem[bus.imem_addr] = bus.imem_data;
            writeCount++;
        end
    end

    typedef struct {
        string      name;
        logic [7:0] lenLo;
        logic [7:0] lenHi;
        logic [7:0] csumDelta;
        int         maxGap;
        logic       expStart;
        logic       expErr;
        int         expWords;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] payload [DEPTH];
    int          compared   = 0;
    int          mismatched = 0;
    int          writeBase  = 0;
    bit          stalled    = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic sendByte(input logic [7:0] b, input int maxGap);
        int waitCycles;
        if (stalled) return;
        repeat ($urandom_range(0, maxGap)) @(negedge clk_i);
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        waitCycles = 0;
        while (!bus.byte_ready && waitCycles < 50) begin
            @(negedge clk_i);
            waitCycles++;
        end
        if (!bus.byte_ready) begin
            stalled = 1'b1;
            checkOutput("byteAccept", 32'(bus.byte_ready), 32'd1);
        end else begin
            @(negedge clk_i);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic doReset();
        int bad;
        bus.byte_valid = 1'b0;
        stalled = 1'b0;
        rst_i = 1'b0;
        #1;
        checkOutput("resetOutputs",
                    32'({bus.byte_ready, bus.imem_we, start_o, done_o, err_o}), 32'd0);
        checkOutput("resetBus", 32'(bus.imem_addr) | bus.imem_data | 32'(word_cnt_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        bad = 0;
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clk_i);
            if (!(bus.imem_we === 1'b1 && bus.imem_addr === ADDR_W'(c) &&
                  bus.imem_data === 32'h0 && bus.byte_ready === 1'b0))
                bad++;
        end
        checkOutput("clearSweep", 32'(bad), 32'd0);
        @(negedge clk_i);
        checkOutput("readyAfterClear", 32'({bus.byte_ready, bus.imem_we}), 32'b10);
        writeBase = writeCount;
    endtask

    // Reference model: N from the two length bytes, XOR of every payload byte, then CSUM.
    task automatic applyStimulus(input logic [7:0] lenLo, input logic [7:0] lenHi,
                                 input logic [7:0] csumDelta, input int maxGap);
        int         n;
        logic [7:0] sum;
        n = int'({lenHi, lenLo});
        sendByte(lenLo, maxGap);
        sendByte(lenHi, maxGap);
        if (n < 1 || n > DEPTH) return;
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                logic [7:0] v;
                v = payload[i][8*b +: 8];
                sum ^= v;
                sendByte(v, maxGap);
            end
        end
        sendByte(sum ^ csumDelta, maxGap);
    endtask

    task automatic checkFrame(input string name, input logic expStart, input logic expErr, input int expWords);
        int bad;
        logic [31:0] expWord;
        checkOutput({name, ".start"}, 32'(start_o), 32'(expStart));
        checkOutput({name, ".done"}, 32'(done_o), 32'(expStart));
        checkOutput({name, ".err"}, 32'(err_o), 32'(expErr));
        checkOutput({name, ".wordCnt"}, 32'(word_cnt_o), 32'(expWords));
        checkOutput({name, ".writes"}, 32'(writeCount - writeBase), 32'(expWords));
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            expWord = (i < expWords) ? payload[i] : 32'h0;
            if (mem[i] !== expWord) bad++;
        end
        checkOutput({name, ".memory"}, 32'(bad), 32'd0);
        bus.byte_data  = 8'hA5;
        bus.byte_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_i);
            if (start_o !== expStart || done_o !== expStart || err_o !== expErr ||
                bus.byte_ready !== 1'b0 || bus.imem_we !== 1'b0)
                bad++;
        end
        bus.byte_valid = 1'b0;
        checkOutput({name, ".holdStable"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int t0;
        int n;
        int expCycles;
        logic [7:0] delta;

        vecs[0] = '{"goodFrame", 8'h02, 8'h00, 8'h00, 0, 1'b1, 1'b0, 2};
        vecs[1] = '{"badCsum",   8'h02, 8'h00, 8'h01, 0, 1'b0, 1'b1, 2};
        vecs[2] = '{"lenZero",   8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1, 0};
        vecs[3] = '{"len257",    8'h01, 8'h01, 8'h00, 0, 1'b0, 1'b1, 0};
        vecs[4] = '{"goodGaps",  8'h02, 8'h00, 8'h00, 5, 1'b1, 1'b0, 2};
        vecs[5] = '{"oneWord",   8'h01, 8'h00, 8'h00, 2, 1'b1, 1'b0, 1};
        vecs[6] = '{"fullDepth", 8'h00, 8'h01, 8'h00, 0, 1'b1, 1'b0, 256};
        vecs[7] = '{"lenFFFF",   8'hFF, 8'hFF, 8'h00, 0, 1'b0, 1'b1, 0};

        bus.byte_data  = 8'h00;
        bus.byte_valid = 1'b0;

        // Write strobe appears exactly one cycle after the 4th byte of a word.
        doReset();
        sendByte(8'h01, 0);
        sendByte(8'h00, 0);
        sendByte(8'hEF, 0);
        sendByte(8'hBE, 0);
        sendByte(8'hAD, 0);
        checkOutput("latency.noEarlyWrite", 32'({bus.imem_we, word_cnt_o}), 32'd0);
        sendByte(8'hDE, 0);
        checkOutput("latency.we", 32'(bus.imem_we), 32'd1);
        checkOutput("latency.addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("latency.data", bus.imem_data, 32'hDEADBEEF);
        checkOutput("latency.wordCnt", 32'(word_cnt_o), 32'd1);
        checkOutput("latency.noStartYet", 32'(start_o), 32'd0);
        sendByte(8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE, 0);
        checkOutput("latency.start", 32'({start_o, done_o, err_o, bus.imem_we}), 32'b1100);

        payload[0] = 32'h00500513;
        payload[1] = 32'h00000033;
        for (int i = 2; i < DEPTH; i++) payload[i] = (32'(i) * 32'h01010101) ^ 32'hA5C3_0000;

        for (int v = 0; v < 8; v++) begin
            doReset();
            t0 = cycleCount;
            applyStimulus(vecs[v].lenLo, vecs[v].lenHi, vecs[v].csumDelta, vecs[v].maxGap);
            if (vecs[v].maxGap == 0) begin
                n = int'({vecs[v].lenHi, vecs[v].lenLo});
                expCycles = (n >= 1 && n <= DEPTH) ? 4 * n + 3 : 2;
                checkOutput({vecs[v].name, ".cycles"}, 32'(cycleCount - t0), 32'(expCycles));
            end
            checkFrame(vecs[v].name, vecs[v].expStart, vecs[v].expErr, vecs[v].expWords);
        end

        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) payload[i] = $urandom;
            delta = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            doReset();
            applyStimulus(8'(n), 8'h00, delta, 5);
            checkFrame($sformatf("rand%0d", it), delta == 8'h00, delta != 8'h00, n);
        end

        // Reset in the middle of a payload, then a clean reload.
        payload[0] = 32'h00500513;
        payload[1] = 32'h00000033;
        doReset();
        sendByte(8'h02, 0);
        sendByte(8'h00, 0);
        for (int b = 0; b < 5; b++) sendByte(payload[b / 4][8*(b % 4) +: 8], 0);
        checkOutput("midReset.preWordCnt", 32'(word_cnt_o), 32'd1);
        #3;
        rst_i = 1'b0;
        #1;
        checkOutput("midReset.cleared",
                    32'({bus.byte_ready, bus.imem_we, start_o, done_o, err_o, word_cnt_o}), 32'd0);
        doReset();
        applyStimulus(8'h02, 8'h00, 8'h00, 1);
        checkFrame("midReset.reload", 1'b1, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
